// File: rtl/vga_sync_decoder.sv
// Recovers pixel position from active-high HSync/VSync, verifies frame timing
// and gates delayed colour with a lock indication.
module vga_sync_decoder #(
  parameter int unsigned TOTAL_COLS  = 800,
  parameter int unsigned TOTAL_ROWS  = 525,
  parameter int unsigned ACTIVE_COLS = 640,
  parameter int unsigned ACTIVE_ROWS = 480,
  parameter int unsigned VIDEO_WIDTH = 3,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_HSync,
  input  logic                   i_VSync,
  input  logic [VIDEO_WIDTH-1:0] i_Red,
  input  logic [VIDEO_WIDTH-1:0] i_Grn,
  input  logic [VIDEO_WIDTH-1:0] i_Blu,
  output logic [9:0]             o_Col_Count,
  output logic [9:0]             o_Row_Count,
  output logic [5:0]             o_Cell_Col,
  output logic [5:0]             o_Cell_Row,
  output logic                   o_Active,
  output logic                   o_Locked,
  output logic                   o_Pixel_Valid,
  output logic [VIDEO_WIDTH-1:0] o_Red,
  output logic [VIDEO_WIDTH-1:0] o_Grn,
  output logic [VIDEO_WIDTH-1:0] o_Blu,
  output logic [7:0]             o_Err_Count
);

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned GOOD_W = 16;
  localparam int unsigned ERR_W  = 8;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(TOTAL_COLS - 1);
  localparam logic [CNT_W-1:0] COL_ACT  = CNT_W'(ACTIVE_COLS - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(TOTAL_ROWS - 1);
  localparam logic [CNT_W-1:0] ROW_ACT  = CNT_W'(ACTIVE_ROWS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Stage 1 capture plus previous-value copy for edge detection
  logic                   hs_s1_q, vs_s1_q;
  logic                   hs_prev_q, vs_prev_q;
  logic [VIDEO_WIDTH-1:0] red_s1_q, grn_s1_q, blu_s1_q;

  // Stage 2 state and outputs
  state_e                 state_q, state_d;
  logic [GOOD_W-1:0]      good_q, good_d;
  logic [CNT_W-1:0]       col_q, col_d;
  logic [CNT_W-1:0]       row_q, row_d;
  logic [ERR_W-1:0]       err_cnt_q, err_cnt_d;
  logic                   active_q, active_d;
  logic                   locked_q, locked_d;
  logic                   valid_q, valid_d;
  logic [VIDEO_WIDTH-1:0] red_q, red_d;
  logic [VIDEO_WIDTH-1:0] grn_q, grn_d;
  logic [VIDEO_WIDTH-1:0] blu_q, blu_d;

  logic hs_rise, hs_fall, vs_rise, vs_fall;
  logic line_err, width_err, frame_err, any_err;
  logic err_inc;
  logic [31:0] good_inc;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hs_s1_q   <= 1'b0;
      vs_s1_q   <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      red_s1_q  <= '0;
      grn_s1_q  <= '0;
      blu_s1_q  <= '0;
    end else begin
      hs_s1_q   <= i_HSync;
      vs_s1_q   <= i_VSync;
      hs_prev_q <= hs_s1_q;
      vs_prev_q <= vs_s1_q;
      red_s1_q  <= i_Red;
      grn_s1_q  <= i_Grn;
      blu_s1_q  <= i_Blu;
    end
  end

  // Edges and timing checks all use the pre-update counter values
  always_comb begin
    hs_rise   = hs_s1_q & ~hs_prev_q;
    hs_fall   = ~hs_s1_q & hs_prev_q;
    vs_rise   = vs_s1_q & ~vs_prev_q;
    vs_fall   = ~vs_s1_q & vs_prev_q;
    line_err  = hs_rise && (col_q != COL_LAST);
    width_err = hs_fall && (col_q != COL_ACT);
    frame_err = (vs_rise && (row_q != ROW_LAST)) ||
                (vs_fall && (row_q != ROW_ACT));
    any_err   = line_err | width_err | frame_err;
  end

  // Position counters run regardless of lock state
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (hs_rise) begin
      col_d = '0;
    end else if (col_q != CNT_MAX) begin
      col_d = col_q + CNT_W'(1);
    end
    if (vs_rise) begin
      row_d = '0;
    end else if (hs_rise && (row_q != CNT_MAX)) begin
      row_d = row_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    err_inc  = 1'b0;
    good_inc = 32'(good_q) + 32'd1;
    unique case (state_q)
      SEARCH: begin
        if (vs_rise) begin
          state_d = CHECK;
          good_d  = '0;
        end
      end
      CHECK: begin
        if (any_err) begin
          state_d = SEARCH;
          err_inc = 1'b1;
        end else if (vs_rise) begin
          good_d = GOOD_W'(good_inc);
          if (good_inc >= 32'(LOCK_FRAMES)) begin
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (any_err) begin
          state_d = SEARCH;
          err_inc = 1'b1;
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  // Lock follows next state so an error drops it in the detecting cycle
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_inc && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
    active_d = hs_s1_q & vs_s1_q;
    locked_d = (state_d == LOCKED);
    valid_d  = active_d & locked_d;
    red_d    = valid_d ? red_s1_q : '0;
    grn_d    = valid_d ? grn_s1_q : '0;
    blu_d    = valid_d ? blu_s1_q : '0;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= SEARCH;
      good_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      err_cnt_q <= '0;
      active_q  <= 1'b0;
      locked_q  <= 1'b0;
      valid_q   <= 1'b0;
      red_q     <= '0;
      grn_q     <= '0;
      blu_q     <= '0;
    end else begin
      state_q   <= state_d;
      good_q    <= good_d;
      col_q     <= col_d;
      row_q     <= row_d;
      err_cnt_q <= err_cnt_d;
      active_q  <= active_d;
      locked_q  <= locked_d;
      valid_q   <= valid_d;
      red_q     <= red_d;
      grn_q     <= grn_d;
      blu_q     <= blu_d;
    end
  end

  assign o_Col_Count   = col_q;
  assign o_Row_Count   = row_q;
  assign o_Cell_Col    = col_q[9:4];
  assign o_Cell_Row    = row_q[9:4];
  assign o_Active      = active_q;
  assign o_Locked      = locked_q;
  assign o_Pixel_Valid = valid_q;
  assign o_Red         = red_q;
  assign o_Grn         = grn_q;
  assign o_Blu         = blu_q;
  assign o_Err_Count   = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced 40x104 raster (38x102
// active) so every lock/relock scenario fits in a short run.
module tb_vga_sync_decoder;

  localparam int TC = 40;
  localparam int AC = 38;
  localparam int TR = 104;
  localparam int AR = 102;
  localparam int LF = 2;
  localparam int VW = 3;

  logic          clk;
  logic          rst_n;
  logic          hs, vs;
  logic [VW-1:0] red, grn, blu;
  logic [9:0]    col_cnt, row_cnt;
  logic [5:0]    cell_col, cell_row;
  logic          active, locked, pix_valid;
  logic [VW-1:0] o_red, o_grn, o_blu;
  logic [7:0]    err_cnt;

  int checks   = 0;
  int failures = 0;

  vga_sync_decoder #(
    .TOTAL_COLS (TC),
    .TOTAL_ROWS (TR),
    .ACTIVE_COLS(AC),
    .ACTIVE_ROWS(AR),
    .VIDEO_WIDTH(VW),
    .LOCK_FRAMES(LF)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_HSync      (hs),
    .i_VSync      (vs),
    .i_Red        (red),
    .i_Grn        (grn),
    .i_Blu        (blu),
    .o_Col_Count  (col_cnt),
    .o_Row_Count  (row_cnt),
    .o_Cell_Col   (cell_col),
    .o_Cell_Row   (cell_row),
    .o_Active     (active),
    .o_Locked     (locked),
    .o_Pixel_Valid(pix_valid),
    .o_Red        (o_red),
    .o_Grn        (o_grn),
    .o_Blu        (o_blu),
    .o_Err_Count  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // After this returns, outputs reflect the pin value applied one tick earlier
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_line(input int len, input int hs_hi, input logic v, input int start);
    for (int i = start; i < len; i++) begin
      hs  = (i < hs_hi);
      vs  = v;
      red = '0;
      grn = '0;
      blu = '0;
      tick();
    end
  endtask

  task automatic drive_rows(input int first, input int last);
    for (int r = first; r <= last; r++) begin
      drive_line(TC, AC, logic'(r < AR), 0);
    end
  endtask

  // Two full frames then the start of a third: lock must appear 2 clocks after the 3rd VSync rise
  task automatic acquire_lock(input string tag, input int exp_err);
    drive_rows(0, TR - 1);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL %s_frame1: o_Locked=%0b expected 0", tag, locked); end
    drive_rows(0, TR - 1);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL %s_frame2: o_Locked=%0b expected 0", tag, locked); end
    hs = 1'b1; vs = 1'b1; tick();
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL %s_early: o_Locked=%0b expected 0 one clock after rise", tag, locked); end
    tick();
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL %s_lock: o_Locked=%0b expected 1 two clocks after rise", tag, locked); end
    checks++; if (err_cnt !== 8'(exp_err)) begin failures++; $display("FAIL %s_err: o_Err_Count=%0d expected %0d", tag, err_cnt, exp_err); end
    checks++; if ({col_cnt, row_cnt} !== 20'd0) begin failures++; $display("FAIL %s_origin: col=%0d row=%0d expected 0/0", tag, col_cnt, row_cnt); end
    drive_line(TC, AC, 1'b1, 2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    hs = 1'b1; vs = 1'b1; red = 3'd7; grn = 3'd7; blu = 3'd7;
    repeat (3) tick();
    checks++; if ({col_cnt, row_cnt} !== 20'd0) begin failures++; $display("FAIL reset_counts: col=%0d row=%0d expected 0/0", col_cnt, row_cnt); end
    checks++; if ({active, locked, pix_valid} !== 3'b000) begin failures++; $display("FAIL reset_flags: act/lock/valid=%b expected 000", {active, locked, pix_valid}); end
    checks++; if ({o_red, o_grn, o_blu} !== 9'd0) begin failures++; $display("FAIL reset_rgb: rgb=%h expected 0", {o_red, o_grn, o_blu}); end
    checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL reset_err: o_Err_Count=%0d expected 0", err_cnt); end
    hs = 1'b0; vs = 1'b0; red = '0; grn = '0; blu = '0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_lock_acquire();
    acquire_lock("lock", 0);
  endtask

  task automatic test_line_error();
    drive_rows(1, 4);
    drive_line(TC - 1, AC, 1'b1, 0);
    hs = 1'b1; vs = 1'b1; tick();
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lerr_hold: o_Locked=%0b expected 1", locked); end
    tick();
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL lerr_drop: o_Locked=%0b expected 0", locked); end
    checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL lerr_count: o_Err_Count=%0d expected 1", err_cnt); end
    drive_line(TC, AC, 1'b1, 2);
    drive_rows(7, TR - 1);
    acquire_lock("relock", 1);
  endtask

  task automatic test_pixel();
    drive_rows(1, 99);
    for (int i = 0; i < TC; i++) begin
      hs = (i < AC);
      vs = 1'b1;
      red = (i >= 37) ? 3'd7 : 3'd1;
      grn = (i >= 37) ? 3'd7 : 3'd2;
      blu = (i >= 37) ? 3'd7 : 3'd4;
      tick();
      if (i == 37) begin
        checks++; if ({o_red, o_grn, o_blu} !== {3'd1, 3'd2, 3'd4}) begin failures++; $display("FAIL pix_chan: rgb=%0d/%0d/%0d expected 1/2/4", o_red, o_grn, o_blu); end
      end
      if (i == 38) begin
        checks++; if ({col_cnt, row_cnt} !== {10'd37, 10'd100}) begin failures++; $display("FAIL pix_pos: col=%0d row=%0d expected 37/100", col_cnt, row_cnt); end
        checks++; if ({cell_col, cell_row} !== {6'd2, 6'd6}) begin failures++; $display("FAIL pix_cell: cell=%0d/%0d expected 2/6", cell_col, cell_row); end
        checks++; if ({active, pix_valid} !== 2'b11) begin failures++; $display("FAIL pix_valid: act/valid=%b expected 11", {active, pix_valid}); end
        checks++; if ({o_red, o_grn, o_blu} !== {3'd7, 3'd7, 3'd7}) begin failures++; $display("FAIL pix_rgb: rgb=%0d/%0d/%0d expected 7/7/7", o_red, o_grn, o_blu); end
      end
      if (i == 39) begin
        checks++; if ({active, pix_valid} !== 2'b00) begin failures++; $display("FAIL blank_flags: act/valid=%b expected 00", {active, pix_valid}); end
        checks++; if ({o_red, o_grn, o_blu} !== 9'd0) begin failures++; $display("FAIL blank_rgb: rgb=%h expected 0", {o_red, o_grn, o_blu}); end
      end
    end
  endtask

  task automatic test_hsync_stuck();
    hs = 1'b0; vs = 1'b1; red = '0; grn = '0; blu = '0;
    repeat (2000) tick();
    checks++; if (col_cnt !== 10'd1023) begin failures++; $display("FAIL stuck_sat: col=%0d expected 1023", col_cnt); end
    checks++; if (row_cnt !== 10'd100) begin failures++; $display("FAIL stuck_row: row=%0d expected 100", row_cnt); end
    hs = 1'b1; tick(); tick();
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL stuck_drop: o_Locked=%0b expected 0", locked); end
    checks++; if (err_cnt !== 8'd2) begin failures++; $display("FAIL stuck_err: o_Err_Count=%0d expected 2", err_cnt); end
    checks++; if ({col_cnt, row_cnt} !== {10'd0, 10'd101}) begin failures++; $display("FAIL stuck_pos: col=%0d row=%0d expected 0/101", col_cnt, row_cnt); end
    drive_line(TC, AC, 1'b1, 2);
    drive_rows(102, TR - 1);
    acquire_lock("stuck_relock", 2);
  endtask

  // Pulse lands mid-line in the vertical blanking of a locked frame
  task automatic test_reset_midframe();
    drive_rows(1, 101);
    drive_line(10, AC, 1'b0, 0);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL mid_prelock: o_Locked=%0b expected 1", locked); end
    rst_n = 1'b0;
    #1;
    checks++; if ({col_cnt, row_cnt, cell_col, cell_row} !== 32'd0) begin failures++; $display("FAIL mid_counts: col=%0d row=%0d expected 0/0", col_cnt, row_cnt); end
    checks++; if ({active, locked, pix_valid, o_red, o_grn, o_blu, err_cnt} !== 20'd0) begin failures++; $display("FAIL mid_outputs: lock=%0b err=%0d expected all zero", locked, err_cnt); end
    #2;
    rst_n = 1'b1;
    drive_line(TC, AC, 1'b0, 10);
    drive_rows(103, TR - 1);
    acquire_lock("reset_relock", 0);
  endtask

  // Each bad line re-enters CHECK on its VSync rise and errors on its early HSync fall
  task automatic test_err_saturate();
    drive_rows(1, 4);
    for (int n = 1; n <= 300; n++) begin
      for (int i = 0; i < 8; i++) begin
        hs = (i < 4);
        vs = (i < 4);
        tick();
      end
      if (n == 10) begin
        checks++; if (err_cnt !== 8'd10) begin failures++; $display("FAIL sat_partial: o_Err_Count=%0d expected 10", err_cnt); end
      end
    end
    checks++; if (err_cnt !== 8'd255) begin failures++; $display("FAIL sat_final: o_Err_Count=%0d expected 255", err_cnt); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL sat_lock: o_Locked=%0b expected 0", locked); end
  endtask

  initial begin
    rst_n = 1'b0;
    hs = 1'b0; vs = 1'b0; red = '0; grn = '0; blu = '0;
    test_reset();
    test_lock_acquire();
    test_line_error();
    test_pixel();
    test_hsync_stuck();
    test_reset_midframe();
    test_err_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameter TOTAL_COLS, default 800, clocks per line.
REQ-002 SHALL have parameter TOTAL_ROWS, default 525, lines per frame.
REQ-003 SHALL have parameter ACTIVE_COLS, default 640, clocks per line with HSync high.
REQ-004 SHALL have parameter ACTIVE_ROWS, default 480, lines per frame with VSync high.
REQ-005 SHALL have parameter VIDEO_WIDTH, default 3, bits per colour channel.
REQ-006 SHALL have parameter LOCK_FRAMES, default 2, consecutive error-free frames required to lock.
REQ-007 SHALL have port i_Clk, input, 1, the single clock; all logic in this domain.
REQ-008 SHALL have port i_Rst_L, input, 1, reset, asynchronous, active-low.
REQ-009 SHALL have ports i_HSync and i_VSync, input, 1 each, high during active columns and active rows respectively.
REQ-010 SHALL have ports i_Red, i_Grn and i_Blu, input, VIDEO_WIDTH each, pixel colour.
REQ-011 SHALL have ports o_Col_Count and o_Row_Count, output, 10 each, recovered position.
REQ-012 SHALL have ports o_Cell_Col and o_Cell_Row, output, 6 each, equal to o_Col_Count[9:4] and o_Row_Count[9:4].
REQ-013 SHALL have port o_Active, output, 1, delayed i_HSync AND i_VSync.
REQ-014 SHALL have port o_Locked, output, 1, timing verified; o_Pixel_Valid, output, 1, o_Active AND o_Locked.
REQ-015 SHALL have ports o_Red, o_Grn and o_Blu, output, VIDEO_WIDTH each, delayed colour, zero when o_Pixel_Valid is low.
REQ-016 SHALL have port o_Err_Count, output, 8, saturating timing-error count.

Function
REQ-017 SHALL register all inputs once (stage 1); edges are detected by comparing stage 1 with its previous value; all outputs are registered (stage 2); pin-to-output latency is 2 clocks.
REQ-018 SHALL, on an HSync rise, set the column to 0; otherwise it increments and saturates at 1023.
REQ-019 SHALL, on an HSync rise, increment the row (saturating at 1023); a VSync rise overrides and sets the row to 0 (a simultaneous rise yields col=0, row=0).
REQ-020 SHALL flag a line error when, on an HSync rise, the pre-update column is not TOTAL_COLS-1.
REQ-021 SHALL flag a width error when, on an HSync fall, the pre-update column is not ACTIVE_COLS-1.
REQ-022 SHALL flag a frame error when, on a VSync rise, the pre-update row is not TOTAL_ROWS-1, or when, on a VSync fall, the pre-update row is not ACTIVE_ROWS-1.
REQ-023 SHALL implement FSM states SEARCH, CHECK and LOCKED; o_Locked is high only in LOCKED.
REQ-024 SHALL, in SEARCH, ignore errors and go to CHECK on a VSync rise with the good-frame count cleared.
REQ-025 SHALL, in CHECK, go to SEARCH on any error; on a VSync rise with no error it increments the good-frame count, and on reaching LOCK_FRAMES it goes to LOCKED.
REQ-026 SHALL, in LOCKED, go to SEARCH on any error, with o_Locked low in the same output cycle that the error is detected.
REQ-027 SHALL increment o_Err_Count once per clock in which at least one error is flagged in CHECK or LOCKED, saturating at 255; it is never incremented in SEARCH.
REQ-028 SHALL keep counters running in all FSM states.

Reset
REQ-029 SHALL, while i_Rst_L is low, asynchronously force all counters, pipeline registers and outputs to 0, o_Err_Count to 0, and the FSM to SEARCH.
REQ-030 SHALL, after deassertion mid-frame, discard the partial frame; lock is reacquired only via SEARCH per REQ-024 and REQ-025.

Verification
REQ-031 SHALL cover: reset released, then nominal 800x525 timing (640x480 active) -> o_Locked rises 2 clocks after the 3rd VSync rise and o_Err_Count stays 0.
REQ-032 SHALL cover: locked, then one line of 799 clocks -> o_Locked falls, o_Err_Count=1, and relock occurs after a further 3 VSync rises.
REQ-033 SHALL cover: locked, with RGB=7/7/7 at col 37, row 100 -> outputs col=37, row=100, cell 2/6, o_Pixel_Valid=1, RGB=7/7/7 exactly 2 clocks later; RGB is 0 during blanking.
REQ-034 SHALL cover: i_HSync held low for 2000 clocks -> o_Col_Count holds at 1023; the next HSync rise flags an error.
REQ-035 SHALL cover: i_Rst_L pulsed low mid-frame while locked -> all outputs are 0 immediately with no clock edge needed, and lock is reacquired per REQ-031.
REQ-036 SHALL cover: 300 bad lines while in CHECK or LOCKED -> o_Err_Count saturates at 255.
